wb_arbiter2: RTL

Two-master, round-robin arbiter that shares one pipelined Wishbone B4 slave port between two pipelined Wishbone masters. It sits between the CPU instruction/data fetch units, or any two bus initiators, and a single slave or interconnect segment. The bus is granted per cycle (CYC), not per strobe. An outstanding-transaction counter routes responses, drops spurious responses, and throttles the owner when the response window is full.

---
 rtl/wb_arbiter2.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter2.sv
// -----------------------------------------------------------------------------
// wb_arbiter2
//
// Round-robin arbiter sharing one pipelined Wishbone B4 slave port between two
// pipelined Wishbone masters. Ownership is granted per bus cycle (CYC), not per
// strobe: once a master owns the bus it keeps it until it drops its CYC.
//
// An outstanding-strobe counter does three jobs:
//   - it routes responses to the owner;
//   - it drops responses that arrive with nothing outstanding;
//   - it throttles the owner once MaxOutstanding strobes are unanswered.
//
// Ports (master vectors are packed with master 0 in the low slice):
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   m_cyc_i[1:0]     per-master CYC
//   m_stb_i[1:0]     per-master STB
//   m_we_i[1:0]      per-master WE
//   m_addr_i         per-master word address (2*AddrWidth)
//   m_data_i         per-master write data   (2*DataWidth)
//   m_sel_i          per-master byte select  (2*SelWidth)
//   m_data_o         slave read data, broadcast to both masters
//   m_ack_o[1:0]     per-master ACK (owner only)
//   m_err_o[1:0]     per-master ERR (owner only)
//   m_stall_o[1:0]   per-master STALL (non-owner always stalled)
//   s_cyc_o          slave CYC
//   s_stb_o          slave STB
//   s_we_o           slave WE
//   s_addr_o         slave address
//   s_data_o         slave write data
//   s_sel_o          slave byte select
//   s_data_i         slave read data
//   s_ack_i          slave ACK
//   s_err_i          slave ERR
//   s_stall_i        slave STALL
//   grant_o[1:0]     one-hot current owner, 2'b00 when idle
// -----------------------------------------------------------------------------
module wb_arbiter2 #(
  parameter  int DataWidth      = 32,
  parameter  int AddrWidth      = 30,
  parameter  int MaxOutstanding = 4,
  localparam int SelWidth       = DataWidth / 8,
  localparam int CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,

  input  logic [1:0]             m_cyc_i,
  input  logic [1:0]             m_stb_i,
  input  logic [1:0]             m_we_i,
  input  logic [2*AddrWidth-1:0] m_addr_i,
  input  logic [2*DataWidth-1:0] m_data_i,
  input  logic [2*SelWidth-1:0]  m_sel_i,
  output logic [DataWidth-1:0]   m_data_o,
  output logic [1:0]             m_ack_o,
  output logic [1:0]             m_err_o,
  output logic [1:0]             m_stall_o,

  output logic                   s_cyc_o,
  output logic                   s_stb_o,
  output logic                   s_we_o,
  output logic [AddrWidth-1:0]   s_addr_o,
  output logic [DataWidth-1:0]   s_data_o,
  output logic [SelWidth-1:0]    s_sel_o,
  input  logic [DataWidth-1:0]   s_data_i,
  input  logic                   s_ack_i,
  input  logic                   s_err_i,
  input  logic                   s_stall_i,

  output logic [1:0]             grant_o
);

  // The grant register doubles as the FSM state. Its encoding is the one-hot
  // owner, so grant_o is simply the state itself.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } grant_e;

  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

  grant_e                grant_q, grant_d;
  logic                  last_q, last_d;     // index of the most recent owner
  logic [CntWidth-1:0]   count_q, count_d;   // accepted but unanswered strobes

  // Owner view of the master-side signals.
  logic                  owner_valid;
  logic                  owner_idx;
  logic                  owner_cyc;
  logic                  owner_stb;
  logic                  full;
  logic                  accept;
  logic                  rsp_fwd;

  assign owner_valid = (grant_q == OWN0) || (grant_q == OWN1);
  assign owner_idx   = (grant_q == OWN1);
  assign full        = (count_q == CntMax);

  // ---------------------------------------------------------------------------
  // Owner mux. With no owner the slave fields fall back to master 0, while
  // CYC/STB stay low so the slave ignores them.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the block can leave a value unassigned and infer a latch.
    owner_cyc = 1'b0;
    owner_stb = 1'b0;
    s_we_o    = m_we_i[0];
    s_addr_o  = m_addr_i[0 +: AddrWidth];
    s_data_o  = m_data_i[0 +: DataWidth];
    s_sel_o   = m_sel_i[0 +: SelWidth];
    if (owner_valid) begin
      owner_cyc = m_cyc_i[owner_idx];
      owner_stb = m_stb_i[owner_idx];
      if (owner_idx) begin
        s_we_o   = m_we_i[1];
        s_addr_o = m_addr_i[AddrWidth +: AddrWidth];
        s_data_o = m_data_i[DataWidth +: DataWidth];
        s_sel_o  = m_sel_i[SelWidth +: SelWidth];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Slave-side request path.
  // ---------------------------------------------------------------------------
  assign s_cyc_o = owner_cyc;
  // A full response window blocks the strobe before the slave can see it.
  assign s_stb_o = owner_stb & owner_cyc & ~full;
  assign accept  = s_stb_o & ~s_stall_i;

  // ---------------------------------------------------------------------------
  // Response path. A response counts only if something is outstanding and the
  // owner is still in its cycle. Responses after an abort, and responses with
  // nothing outstanding, are swallowed here.
  // ---------------------------------------------------------------------------
  assign rsp_fwd  = (s_ack_i | s_err_i) & (count_q != '0) & owner_cyc;
  assign m_data_o = s_data_i;

  always_comb begin
    m_ack_o   = 2'b00;
    m_err_o   = 2'b00;
    m_stall_o = 2'b11;
    if (owner_valid) begin
      m_stall_o[owner_idx] = s_stall_i | full;
      // ERR wins over a simultaneous ACK.
      m_err_o[owner_idx]   = rsp_fwd & s_err_i;
      m_ack_o[owner_idx]   = rsp_fwd & s_ack_i & ~s_err_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration. Re-arbitrate whenever nobody holds the bus: no owner, or the
  // owner has dropped CYC. While the owner keeps CYC high the grant is frozen.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_d = grant_q;
    last_d  = last_q;
    if (!owner_cyc) begin
      unique case (m_cyc_i)
        2'b01:   grant_d = OWN0;
        2'b10:   grant_d = OWN1;
        // Tie: the master that did not own the bus last time goes first.
        2'b11:   grant_d = last_q ? OWN0 : OWN1;
        default: grant_d = IDLE;
      endcase
      if (grant_d != IDLE) begin
        last_d = (grant_d == OWN1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outstanding counter. When the owner leaves its cycle (including an abort
  // with strobes still pending) the window is discarded, so late responses
  // land on a zero count and get dropped. Accept and response are mutually
  // bounded: accept needs !full, response needs count > 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d = count_q;
    if (!owner_cyc) begin
      count_d = '0;
    end else begin
      unique case ({accept, rsp_fwd})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers. last resets to master 1 so master 0 wins the first tie.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_ni) begin
      grant_q <= IDLE;
      last_q  <= 1'b1;
      count_q <= '0;
    end else begin
      grant_q <= grant_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  assign grant_o = grant_q;

endmodule
